rtc_set_ctrl: RTL

- Single-clock real-time-clock controller. It generates a 1 Hz tick enable from the 50 MHz system clock and sequences the seconds, minutes and hours counters with carry.
- A two-button user interface (mode, increment) lets the operator set the time.
- Sits between the board push-buttons and the 7-segment display driver.
- The whole block runs on clk; no derived clocks are used.

---
 rtl/rtc_set_ctrl_if.sv | 14 +
 rtl/rtc_set_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/rtc_set_ctrl_if.sv
// rtc_set_ctrl_if: tick period, raw buttons and time/mode display fields of the RTC set controller
interface rtc_set_ctrl_if;
   logic [31:0] num;
   logic        btn_mode;
   logic        btn_inc;
   logic [5:0]  sec;
   logic [5:0]  min;
   logic [4:0]  hour;
   logic [1:0]  mode;
   logic        blink;
   logic        tick;
   modport master (output num, btn_mode, btn_inc, input sec, min, hour, mode, blink, tick);
   modport slave (input num, btn_mode, btn_inc, output sec, min, hour, mode, blink, tick);
endinterface

// File: rtl/rtc_set_ctrl.sv
// rtc_set_ctrl: tick divider, sec/min/hour counters with carry and two-button time set; AUTO_REPEAT_EN adds held-inc auto-repeat
module rtc_set_ctrl #(
   parameter int HOUR_MAX = 23
`ifdef AUTO_REPEAT_EN
   , parameter int REPEAT_DLY = 2
`endif
) (
   input logic           clk,
   input logic           rst_n,
   rtc_set_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'd0, SET_SEC = 2'd1, SET_MIN = 2'd2, SET_HOUR = 2'd3} state_e;
   state_e      state, state_nxt;
   logic [31:0] cnt, cnt_nxt, n;
   logic [5:0]  sec, sec_nxt, min, min_nxt;
   logic [4:0]  hour, hour_nxt;
   logic        blink, blink_nxt;
   logic [1:0]  mode_sync, inc_sync;
   logic        mode_prev, inc_prev;
   logic        mode_edge, inc_edge, inc_ev, wrap;
   logic        sec_last, min_last, hour_last;
   assign n         = (bus.num < 32'd2) ? 32'd2 : bus.num;
   assign wrap      = cnt >= n - 32'd1;
   assign mode_edge = mode_sync[1] & ~mode_prev;
   assign inc_edge  = inc_sync[1] & ~inc_prev;
   assign sec_last  = sec == 6'd59;
   assign min_last  = min == 6'd59;
   assign hour_last = hour == 5'(HOUR_MAX);
   // two-stage synchronizers plus previous-value registers for rising-edge detection
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mode_sync <= '0;
         inc_sync  <= '0;
         mode_prev <= 1'b0;
         inc_prev  <= 1'b0;
      end else begin
         mode_sync <= {mode_sync[0], bus.btn_mode};
         inc_sync  <= {inc_sync[0], bus.btn_inc};
         mode_prev <= mode_sync[1];
         inc_prev  <= inc_sync[1];
      end
`ifdef AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_DLY + 1) + 1;
   logic [RW-1:0] rep_cnt;
   // ticks elapsed while inc stays held in a SET state, saturating at the repeat delay
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rep_cnt <= '0;
      else if (state == RUN || !inc_sync[1]) rep_cnt <= '0;
      else if (wrap && rep_cnt < RW'(REPEAT_DLY)) rep_cnt <= rep_cnt + 1'b1;
   assign inc_ev = inc_edge | (inc_sync[1] && wrap && state != RUN && rep_cnt >= RW'(REPEAT_DLY));
`else
   assign inc_ev = inc_edge;
`endif
   // state, divider and time fields register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= RUN;
         cnt   <= '0;
         sec   <= '0;
         min   <= '0;
         hour  <= '0;
         blink <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sec   <= sec_nxt;
         min   <= min_nxt;
         hour  <= hour_nxt;
         blink <= blink_nxt;
      end
   // next state: time advance with carry in RUN, field set and blink in SET states, mode edge has priority
   always_comb begin
      state_nxt = state;
      cnt_nxt   = wrap ? '0 : cnt + 32'd1;
      sec_nxt   = sec;
      min_nxt   = min;
      hour_nxt  = hour;
      blink_nxt = blink;
      if (state == RUN) begin
         if (wrap) begin
            sec_nxt = sec_last ? '0 : sec + 6'd1;
            if (sec_last) min_nxt = min_last ? '0 : min + 6'd1;
            if (sec_last && min_last) hour_nxt = hour_last ? '0 : hour + 5'd1;
         end
         if (mode_edge) begin
            state_nxt = SET_SEC;
            blink_nxt = 1'b1;
         end
      end else if (mode_edge) begin
         state_nxt = state == SET_SEC ? SET_MIN : state == SET_MIN ? SET_HOUR : RUN;
         blink_nxt = state != SET_HOUR;
         if (state == SET_HOUR) cnt_nxt = '0;
      end else begin
         if (wrap) blink_nxt = ~blink;
         if (inc_ev && state == SET_SEC) sec_nxt = sec_last ? '0 : sec + 6'd1;
         if (inc_ev && state == SET_MIN) min_nxt = min_last ? '0 : min + 6'd1;
         if (inc_ev && state == SET_HOUR) hour_nxt = hour_last ? '0 : hour + 5'd1;
      end
   end
   assign bus.sec   = sec;
   assign bus.min   = min;
   assign bus.hour  = hour;
   assign bus.mode  = state;
   assign bus.blink = blink;
   assign bus.tick  = wrap;
endmodule
